// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory read issue, 2-entry
// instruction buffer and valid/ready handoff to decode, with redirect flush.
// Optional build macro FETCH_BYPASS_EN: when the buffer is empty, a
// live memory response is presented to decode combinationally (1-cycle latency).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_hit,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [31:0] LAST_PC = 32'((MEM_WORDS - 1) * 4);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;
  logic [1:0][31:0] ent_instr_q, ent_instr_d;
  logic [1:0][31:0] ent_pc_q, ent_pc_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic resp, bypass, pop, fifo_pop, push, issue, wr_ptr;

  // Target low bits are discarded by design.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Response qualification, decode-side outputs, handshake and issue decision
  always_comb begin
    // A response arriving in a redirect cycle is wrong-path and is dropped.
    resp = rst & inflight_q & ~kill_q & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
    bypass = resp & (count_q == 2'd0);
`else
    bypass = 1'b0;
`endif
    if_valid = rst & ((count_q != 2'd0) | bypass);
    if_instr = 32'h0;
    if_pc    = 32'h0;
    if (rst) begin
      if (bypass) begin
        if_instr = imem_instr;
        if_pc    = tag_q;
      end else begin
        if_instr = ent_instr_q[rd_ptr_q];
        if_pc    = ent_pc_q[rd_ptr_q];
      end
    end
    pop      = if_valid & if_ready;
    fifo_pop = pop & ~bypass;
    // A bypassed response taken by decode this cycle never enters the buffer.
    push     = resp & ~(bypass & if_ready);
    // Issue only if the buffer can absorb everything outstanding after this pop.
    issue    = rst & ~redirect_valid &
               (({1'b0, count_q} + {2'b0, inflight_q}) <= ({2'b0, pop} + 3'd1));
    imem_hit  = issue;
    imem_addr = rst ? pc_q : RESET_PC;
  end

  // Next-state: PC advance/wrap, buffer push/pop, redirect flush
  always_comb begin
    pc_d        = pc_q;
    tag_d       = tag_q;
    inflight_d  = issue;
    kill_d      = 1'b0;
    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    // At count 2 a push only happens with a pop, so it lands in the slot being freed.
    wr_ptr      = rd_ptr_q ^ count_q[0];
    if (issue) begin
      tag_d = pc_q;
      pc_d  = (pc_q == LAST_PC) ? 32'h0 : pc_q + 32'd4;
    end
    if (push) begin
      ent_instr_d[wr_ptr] = imem_instr;
      ent_pc_d[wr_ptr]    = tag_q;
    end
    if (fifo_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, fifo_pop};
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      kill_d  = inflight_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer payload needs no reset; it is only visible behind count/valid
  always_ff @(posedge clk) begin
    ent_instr_q <= ent_instr_d;
    ent_pc_q    <= ent_pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized ready/redirect/reset
// traffic. The reference model treats fetch as a program-order stream:
// issued addresses and delivered (instr, pc) pairs must each follow
// pc, next(pc), ... restarting at the reset PC or a redirect target.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          MEM_WORDS = 200;
  localparam logic [31:0] LAST_PC   = 32'((MEM_WORDS - 1) * 4);
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0, rst = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = 32'h0, imem_instr = 32'h0;
  logic        imem_hit, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] exp_pc, exp_fetch;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_hit(imem_hit), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  // Synchronous instruction memory: registers the word on a hit, holds otherwise.
  always @(posedge clk) if (imem_hit) imem_instr <= mem[int'(imem_addr >> 2)];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] p);
    return (p == LAST_PC) ? 32'h0 : p + 32'd4;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Stream-order reference: checks every issue and every decode transfer.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_hit", 32'(imem_hit), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      exp_pc    = RESET_PC;
      exp_fetch = RESET_PC;
    end else begin
      if (if_valid && if_ready) begin
        chk("pop_pc", if_pc, exp_pc);
        chk("pop_instr", if_instr, mem[int'(exp_pc >> 2)]);
        exp_pc = next_pc(exp_pc);
      end
      if (redirect_valid) begin
        chk("redir_no_issue", 32'(imem_hit), 32'd0);
        exp_fetch = {redirect_pc[31:2], 2'b00};
        exp_pc    = exp_fetch;
      end else if (imem_hit) begin
        chk("issue_addr", imem_addr, exp_fetch);
        exp_fetch = next_pc(exp_fetch);
      end
    end
  end

  task automatic redirect_check(input logic [31:0] tgt, input logic [31:0] exp_addr);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    cyc();
    redirect_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("redir_addr", imem_addr, exp_addr);
        chk("redir_issue", 32'(imem_hit), 32'd1);
      end
      chk("redir_valid", 32'(if_valid), 32'(k == LAT + 1));
      if (k == LAT + 1) chk("redir_pc", if_pc, exp_addr);
      cyc();
    end
  endtask

  initial begin
    int hits;
    logic last_hit;
    logic [31:0] wrap_exp [3];
    wrap_exp = '{32'h318, 32'h31C, 32'h0};
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;

    // Reset state
    if_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    cyc();

    // Release: back-to-back issue and delivery after the fetch latency
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk("seq_addr", imem_addr, 32'(c * 4));
        chk("seq_hit", 32'(imem_hit), 32'd1);
      end
      chk("seq_valid", 32'(if_valid), 32'(c >= LAT));
      if (c >= LAT && c < LAT + 4) begin
        chk("seq_pc", if_pc, 32'((c - LAT) * 4));
        chk("seq_instr", if_instr, 32'(11 * (c - LAT + 1)));
      end
      cyc();
    end

    // Decode stall: issue stops with at most two outstanding, nothing lost
    if_ready = 1'b0;
    hits = 0;
    last_hit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      hits += int'(imem_hit);
      last_hit = imem_hit;
      chk("stall_valid", 32'(if_valid), 32'd1);
      cyc();
    end
    chk("stall_hits_le2", 32'(hits <= 2), 32'd1);
    chk("stall_hit_end", 32'(last_hit), 32'd0);
    if_ready = 1'b1;
    repeat (4) cyc();

    // Redirects: in-flight read dropped, low bits ignored, last one wins
    redirect_check(32'h40, 32'h40);
    repeat (3) cyc();
    redirect_check(32'h43, 32'h40);
    repeat (3) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h20; cyc();
    redirect_pc = 32'h80; cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("dbl_redir_addr", imem_addr, 32'h80);
    cyc();
    repeat (5) cyc();

    // PC wrap at the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'h318; cyc();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrap_addr", imem_addr, wrap_exp[k]);
      cyc();
    end
    repeat (4) cyc();

    // One-cycle reset mid-stream
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_hit", 32'(imem_hit), 32'd0);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    cyc();
    rst = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("restart_addr", imem_addr, RESET_PC);
        chk("restart_hit", 32'(imem_hit), 32'd1);
      end
      chk("restart_valid", 32'(if_valid), 32'(k == LAT));
      if (k == LAT) chk("restart_pc", if_pc, RESET_PC);
      cyc();
    end

    // Randomized traffic against the stream model
    for (int n = 0; n < 3000; n++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = LAST_PC - 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      else
        redirect_pc = 32'($urandom_range(0, MEM_WORDS - 1) * 4 + $urandom_range(0, 3));
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
